e_muldiv: RTL and testbench
===========================

# e_muldiv

Multi-cycle multiply/divide unit for the E stage of the five-stage pipeline, consuming the instruction and forwarded operand values presented by the D→E pipeline register. It holds HI/LO, runs mult/multu/div/divu with fixed latencies, and handles mfhi/mflo/mthi/mtlo. It raises a stall request so the hazard logic can freeze PC and the D register and insert a bubble into E while a D-stage mult/div-class instruction must wait.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- e_instr  in  32  instruction currently in E (0 = nop/bubble)
- e_rs  in  32  forwarded rs value for e_instr
- e_rt  in  32  forwarded rt value for e_instr
- d_is_md  in  1  D-stage instruction is any of the 8 md-class ops
- start  out  1  combinational: e_instr is mult/multu/div/divu and busy=0
- busy  out  1  registered: operation in flight
- stall  out  1  combinational: d_is_md & (start | busy)
- md_out  out  32  combinational: hi if e_instr is mfhi, lo if mflo, else 0
- hi  out  32  committed HI register
- lo  out  32  committed LO register

## Operation
- Decode: opcode[31:26]=0; funct[5:0]: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x12 mflo, 0x11 mthi, 0x13 mtlo. Any other instruction: no effect.
- State: IDLE (busy=0), RUN (busy=1, down-counter cnt).
- IDLE, start=1 at posedge: compute result into pending registers (p_hi, p_lo) from e_rs/e_rt; cnt ← MULT_CYCLES or DIV_CYCLES; go to RUN. hi/lo unchanged.
- RUN: each posedge cnt ← cnt−1; on the edge where cnt==1, hi←p_hi, lo←p_lo, busy←0, return to IDLE.
- Arithmetic: mult = signed 32×32→64, multu = unsigned; {hi,lo} = product. div/divu: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign. 0x80000000 div 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero (e_rt=0, div or divu): still RUN for DIV_CYCLES; hi/lo unchanged at completion.
- mthi/mtlo in E at posedge with busy=0: hi←e_rs / lo←e_rs. With busy=1: ignored (cannot occur when stall is honoured).
- mult/div-class in E with busy=1: start=0, request dropped, no state change.
- mfhi/mflo: md_out reads committed hi/lo combinationally; no state change.
- stall protects every md-class D instruction, including mfhi/mflo/mthi/mtlo, from overlapping an in-flight or starting operation.

## Timing
- Reset values: busy=0, cnt=0, hi=0, lo=0, p_hi=0, p_lo=0. start, stall and md_out follow from inputs.
- Start edge T: busy=1 from T through T+N−1 edges (exactly N cycles high, N = MULT_CYCLES or DIV_CYCLES); hi/lo show the new result in the cycle after edge T+N, when busy has just fallen.
- Back-to-back: a new start is accepted on the first cycle busy=0.
- mthi/mtlo: new value visible on hi/lo and md_out the cycle after the write edge.
- Reset mid-RUN: next edge returns to IDLE, busy=0, hi=lo=0, pending result discarded.
- Reset has priority over start and mt*.

## Test plan
- Reset then idle: hi=lo=0, busy=0, stall=0, md_out=0 for mfhi.
- mult e_rs=0xFFFFFFFD, e_rt=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; multu on same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- divu 7/2 -> busy 10 cycles, lo=3, hi=1; div 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- div by zero with hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo still 0x11/0x22.
- d_is_md=1 during start cycle and all busy cycles -> stall=1; stall=0 in the first cycle busy=0; d_is_md=0 -> stall=0 throughout.
- mthi e_rs=0xABCD then mfhi -> md_out=0xABCD; reset asserted at cycle 3 of a div -> busy=0 next cycle, hi=lo=0, no late write-back.

Source files
------------

// File: rtl/e_muldiv.sv
// Multi-cycle multiply/divide unit for the E stage: holds HI/LO, runs
// mult/multu/div/divu with fixed latencies and services mfhi/mflo/mthi/mtlo.
module e_muldiv #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] e_instr,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        p_hi_q, p_hi_d;
  logic [31:0]        p_lo_q, p_lo_d;
  logic               p_we_q, p_we_d;

  logic               rtype;
  logic [5:0]         funct;
  logic               is_mult, is_multu, is_div, is_divu;
  logic               is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic               is_mul_cls, is_div_cls, is_md_op;

  logic [63:0]        prod_s, prod_u, prod;
  logic               a_neg, b_neg;
  logic [31:0]        mag_a, mag_b, safe_b;
  logic [31:0]        uq, ur, quot, rem;
  logic               div_zero;

  logic               unused_instr_bits;

  // Instruction decode; rs/rt/rd/shamt fields do not affect this unit
  always_comb begin
    rtype      = (e_instr[31:26] == 6'd0);
    funct      = e_instr[5:0];
    is_mult    = rtype && (funct == F_MULT);
    is_multu   = rtype && (funct == F_MULTU);
    is_div     = rtype && (funct == F_DIV);
    is_divu    = rtype && (funct == F_DIVU);
    is_mfhi    = rtype && (funct == F_MFHI);
    is_mflo    = rtype && (funct == F_MFLO);
    is_mthi    = rtype && (funct == F_MTHI);
    is_mtlo    = rtype && (funct == F_MTLO);
    is_mul_cls = is_mult || is_multu;
    is_div_cls = is_div || is_divu;
    is_md_op   = is_mul_cls || is_div_cls;
  end

  assign unused_instr_bits = ^e_instr[25:6];

  // Product and quotient/remainder from the forwarded operands
  always_comb begin
    prod_s   = {{32{e_rs[31]}}, e_rs} * {{32{e_rt[31]}}, e_rt};
    prod_u   = {32'd0, e_rs} * {32'd0, e_rt};
    prod     = is_mult ? prod_s : prod_u;

    // Signed divide works on magnitudes, then restores signs: quotient
    // truncates toward zero and the remainder follows the dividend.
    a_neg    = is_div && e_rs[31];
    b_neg    = is_div && e_rt[31];
    mag_a    = a_neg ? (32'd0 - e_rs) : e_rs;
    mag_b    = b_neg ? (32'd0 - e_rt) : e_rt;
    div_zero = (e_rt == 32'd0);
    safe_b   = div_zero ? 32'd1 : mag_b;
    uq       = mag_a / safe_b;
    ur       = mag_a % safe_b;
    quot     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem      = a_neg ? (32'd0 - ur) : ur;
  end

  // Next-state, counter, pending result and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_we_d  = p_we_q;
    case (state_q)
      S_IDLE: begin
        if (is_md_op) begin
          state_d = S_RUN;
          if (is_mul_cls) begin
            cnt_d  = CNT_W'(MULT_CYCLES);
            p_hi_d = prod[63:32];
            p_lo_d = prod[31:0];
            p_we_d = 1'b1;
          end else begin
            cnt_d  = CNT_W'(DIV_CYCLES);
            p_hi_d = rem;
            p_lo_d = quot;
            p_we_d = !div_zero;
          end
        end else begin
          if (is_mthi) hi_d = e_rs;
          if (is_mtlo) lo_d = e_rs;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (p_we_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_we_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_we_q  <= p_we_d;
    end
  end

  // Pipeline-facing handshake and move-from read port
  always_comb begin
    busy  = (state_q == S_RUN);
    start = is_md_op && !busy;
    stall = d_is_md && (start || busy);
    if (is_mfhi)      md_out = hi_q;
    else if (is_mflo) md_out = lo_q;
    else              md_out = 32'd0;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// Self-checking bench for e_muldiv: transaction-level model plus directed
// literal checks and randomized instruction streams.
module tb_e_muldiv;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] e_instr, e_rs, e_rt;
  logic        d_is_md;
  logic        start, busy, stall;
  logic [31:0] md_out, hi, lo;

  always #5 clk = ~clk;

  e_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .e_instr(e_instr), .e_rs(e_rs), .e_rt(e_rt),
    .d_is_md(d_is_md), .start(start), .busy(busy), .stall(stall),
    .md_out(md_out), .hi(hi), .lo(lo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: committed HI/LO, pending result and the edge at which it commits
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_busy, m_pwe;
  int          m_done, ecnt;

  function automatic logic [31:0] rt_op(input logic [5:0] f);
    rt_op = {6'd0, 20'($urandom), f};
  endfunction

  function automatic bit is_md(input logic [31:0] i);
    is_md = (i[31:26] == 6'd0) && (i[5:0] >= 6'h18) && (i[5:0] <= 6'h1B);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, ecnt, act, exp);
    end
  endtask

  // Apply the inputs the DUT just sampled to the model
  task automatic model_edge();
    longint sa, sb, q, r;
    logic [63:0] pu;
    ecnt++;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_pwe = 0;
    end else if (m_busy) begin
      if (ecnt == m_done) begin
        m_busy = 0;
        if (m_pwe) begin m_hi = m_phi; m_lo = m_plo; end
      end
    end else if (e_instr[31:26] == 6'd0) begin
      case (e_instr[5:0])
        6'h18: begin
          sa = longint'($signed(e_rs)); sb = longint'($signed(e_rt));
          q = sa * sb; m_phi = 32'(q >>> 32); m_plo = 32'(q);
          m_pwe = 1; m_busy = 1; m_done = ecnt + MC;
        end
        6'h19: begin
          pu = {32'd0, e_rs} * {32'd0, e_rt};
          m_phi = pu[63:32]; m_plo = pu[31:0];
          m_pwe = 1; m_busy = 1; m_done = ecnt + MC;
        end
        6'h1A: begin
          m_pwe = (e_rt != 0);
          if (m_pwe) begin
            sa = longint'($signed(e_rs)); sb = longint'($signed(e_rt));
            q = sa / sb; r = sa % sb;
            m_plo = 32'(q); m_phi = 32'(r);
          end
          m_busy = 1; m_done = ecnt + DC;
        end
        6'h1B: begin
          m_pwe = (e_rt != 0);
          if (m_pwe) begin m_plo = e_rs / e_rt; m_phi = e_rs % e_rt; end
          m_busy = 1; m_done = ecnt + DC;
        end
        6'h11: m_hi = e_rs;
        6'h13: m_lo = e_rs;
        default: ;
      endcase
    end
  endtask

  // Compare every output against the model
  task automatic check_cycle();
    bit exp_start, exp_stall;
    logic [31:0] exp_md;
    exp_start = is_md(e_instr) && !m_busy;
    exp_stall = d_is_md && (exp_start || m_busy);
    exp_md = 32'd0;
    if (e_instr[31:26] == 6'd0 && e_instr[5:0] == 6'h10) exp_md = m_hi;
    if (e_instr[31:26] == 6'd0 && e_instr[5:0] == 6'h12) exp_md = m_lo;
    chk("busy",   {31'd0, busy},  {31'd0, m_busy});
    chk("start",  {31'd0, start}, {31'd0, exp_start});
    chk("stall",  {31'd0, stall}, {31'd0, exp_stall});
    chk("md_out", md_out, exp_md);
    chk("hi",     hi, m_hi);
    chk("lo",     lo, m_lo);
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                      input logic dmd, input logic rst);
    @(posedge clk);
    model_edge();
    #1;
    e_instr = i; e_rs = rs; e_rt = rt; d_is_md = dmd; reset = rst;
    #1;
    check_cycle();
  endtask

  // Issue one md op and count the cycles busy stays high
  task automatic run_op(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                        input logic dmd, output int nbusy);
    bit done;
    nbusy = 0;
    done = 0;
    step(i, rs, rt, dmd, 1'b0);
    for (int k = 0; k < 100; k++) begin
      step(32'd0, 32'd0, 32'd0, dmd, 1'b0);
      if (busy) nbusy++;
      else begin done = 1; break; end
    end
    if (!done) begin
      n_bad++;
      $display("FAIL busy_timeout: busy still high after 100 cycles");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'd0;
      1: pick = 32'd1;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  int nb;
  logic [31:0] ri;
  logic [5:0] rf;

  initial begin
    ecnt = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_busy = 0; m_pwe = 0; m_done = 0;
    e_instr = 0; e_rs = 0; e_rt = 0; d_is_md = 0; reset = 1;
    step(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(rt_op(6'h10), 32'd0, 32'd0, 1'b1, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mfhi", md_out, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    run_op(rt_op(6'h18), 32'hFFFF_FFFD, 32'd5, 1'b1, nb);
    chk("mult_busy_cycles", 32'(nb), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("stall_after_busy", {31'd0, stall}, 32'd0);

    run_op(rt_op(6'h19), 32'hFFFF_FFFD, 32'd5, 1'b0, nb);
    chk("multu_hi", hi, 32'h0000_0004);
    chk("multu_lo", lo, 32'hFFFF_FFF1);

    run_op(rt_op(6'h1B), 32'd7, 32'd2, 1'b1, nb);
    chk("divu_busy_cycles", 32'(nb), 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run_op(rt_op(6'h1A), 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(rt_op(6'h1A), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    step(rt_op(6'h11), 32'h11, 32'd0, 1'b0, 1'b0);
    step(rt_op(6'h13), 32'h22, 32'd0, 1'b0, 1'b0);
    run_op(rt_op(6'h1B), 32'd1234, 32'd0, 1'b1, nb);
    chk("div0_busy_cycles", 32'(nb), 32'd10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    step(rt_op(6'h11), 32'hABCD, 32'd0, 1'b0, 1'b0);
    step(rt_op(6'h10), 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mthi_mfhi", md_out, 32'hABCD);

    // Reset during the third busy cycle of a divide
    step(rt_op(6'h1A), 32'd100, 32'd7, 1'b0, 1'b0);
    step(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    for (int k = 0; k < 15; k++) step(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("no_late_wb_hi", hi, 32'd0);
    chk("no_late_wb_lo", lo, 32'd0);

    // Randomized instruction stream, including ops dropped while busy
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3: ri = rt_op(6'h18 + 6'($urandom_range(0, 3)));
        4:  ri = rt_op(6'h10);
        5:  ri = rt_op(6'h12);
        6:  ri = rt_op(6'h11);
        7:  ri = rt_op(6'h13);
        8:  begin
              rf = 6'h10 + 6'($urandom_range(0, 11));
              ri = {6'($urandom_range(1, 63)), 20'($urandom), rf};
            end
        default: ri = 32'd0;
      endcase
      step(ri, pick(), pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
